csr_file: RTL and testbench

- Parametrised successor to the core's CSR register block: machine-mode CSRs plus 64-bit cycle/instret counters, two read/write ports (execute stage, CLINT).
- Each write port does atomic write/set/clear (CSRRW/CSRRS/CSRRC) internally, so callers no longer compute read-modify-write values.
- Exports global interrupt enable and per-source enables to the CLINT.
- Sits beside the register file; read by ex, written by ex and clint.

---
 rtl/csr_file_pkg.sv | 29 ++
 rtl/csr_counter.sv | 26 ++
 rtl/csr_file.sv | 120 ++++++++++++
 tb/tb_csr_file.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/csr_file_pkg.sv
// csr_file_pkg: CSR addresses, op encodings, WARL masks and the read-modify-write helper
package csr_file_pkg;
  typedef enum logic [1:0] {
    CSR_OP_NONE  = 2'b00,
    CSR_OP_WRITE = 2'b01,
    CSR_OP_SET   = 2'b10,
    CSR_OP_CLEAR = 2'b11
  } csr_op_e;
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [63:0] MSTATUS_WMASK = 64'h88;
  localparam logic [63:0] MIE_WMASK     = 64'h888;
  localparam logic [63:0] ALIGN_MASK    = ~64'h3;
  function automatic logic [63:0] csr_apply(input csr_op_e op, input logic [63:0] old, input logic [63:0] d);
    return op == CSR_OP_WRITE ? d : op == CSR_OP_SET ? old | d : op == CSR_OP_CLEAR ? old & ~d : old;
  endfunction
endpackage

// File: rtl/csr_counter.sv
// csr_counter: free-running counter with independent low/high half writes that suppress the increment
module csr_counter #(
  parameter int CNT_W = 64,
  parameter int XLEN  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc_i,
  input  logic                  wr_lo_i,
  input  logic                  wr_hi_i,
  input  logic [XLEN-1:0]       wdata_lo_i,
  input  logic [CNT_W-XLEN-1:0] wdata_hi_i,
  output logic [CNT_W-1:0]      q_o
);
  logic [CNT_W-1:0] cnt_d, cnt_q;
  always_comb begin
    cnt_d = (wr_lo_i || wr_hi_i)
          ? {wr_hi_i ? wdata_hi_i : cnt_q[CNT_W-1:XLEN], wr_lo_i ? wdata_lo_i : cnt_q[XLEN-1:0]}
          : cnt_q + CNT_W'(inc_i);
  end
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign q_o = cnt_q;
endmodule

// File: rtl/csr_file.sv
// csr_file: machine-mode CSRs and cycle/instret counters with two atomic read/write ports
module csr_file
  import csr_file_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              CNT_W       = 64,
  parameter logic [XLEN-1:0] MTVEC_RST   = '0,
  parameter bit              HAS_INSTRET = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instret_i,
  input  logic [1:0]      ex_op_i,
  input  logic [11:0]     ex_waddr_i,
  input  logic [XLEN-1:0] ex_wdata_i,
  input  logic [11:0]     ex_raddr_i,
  output logic [XLEN-1:0] ex_rdata_o,
  output logic            ex_illegal_o,
  input  logic [1:0]      clint_op_i,
  input  logic [11:0]     clint_waddr_i,
  input  logic [XLEN-1:0] clint_wdata_i,
  input  logic [11:0]     clint_raddr_i,
  output logic [XLEN-1:0] clint_rdata_o,
  output logic            global_int_en_o,
  output logic [XLEN-1:0] mie_o
);
  localparam int HW = CNT_W - XLEN;
  localparam logic [XLEN-1:0] MST_M = XLEN'(MSTATUS_WMASK);
  localparam logic [XLEN-1:0] MIE_M = XLEN'(MIE_WMASK);
  localparam logic [XLEN-1:0] ALN_M = XLEN'(ALIGN_MASK);
  logic [XLEN-1:0] mstatus_d, mstatus_q, mie_d, mie_q, mtvec_d, mtvec_q;
  logic [XLEN-1:0] mscratch_d, mscratch_q, mepc_d, mepc_q, mcause_d, mcause_q;
  logic [CNT_W-1:0] mcycle_q, minstret_q;
  logic [XLEN:0] ex_rd, cl_rd, ex_old, cl_old;
  logic [XLEN-1:0] ex_nv, cl_nv;
  logic ex_we, cl_we;
  function automatic logic [XLEN:0] csr_read(input logic [11:0] a);
    case (a)
      CSR_MSTATUS:                return {1'b0, mstatus_q};
      CSR_MIE:                    return {1'b0, mie_q};
      CSR_MTVEC:                  return {1'b0, mtvec_q};
      CSR_MSCRATCH:               return {1'b0, mscratch_q};
      CSR_MEPC:                   return {1'b0, mepc_q};
      CSR_MCAUSE:                 return {1'b0, mcause_q};
      CSR_MCYCLE, CSR_CYCLE:      return {1'b0, mcycle_q[XLEN-1:0]};
      CSR_MCYCLEH, CSR_CYCLEH:    return {1'b0, XLEN'(mcycle_q[CNT_W-1:XLEN])};
      CSR_MINSTRET, CSR_INSTRET:  return HAS_INSTRET ? {1'b0, minstret_q[XLEN-1:0]} : {1'b1, {XLEN{1'b0}}};
      CSR_MINSTRETH, CSR_INSTRETH: return HAS_INSTRET ? {1'b0, XLEN'(minstret_q[CNT_W-1:XLEN])} : {1'b1, {XLEN{1'b0}}};
      default:                    return {1'b1, {XLEN{1'b0}}};
    endcase
  endfunction
  function automatic logic wr_hit(input logic [11:0] a);
    return (ex_we && ex_waddr_i == a) || (cl_we && clint_waddr_i == a);
  endfunction
  function automatic logic [XLEN-1:0] wr_val(input logic [11:0] a, input logic [XLEN-1:0] cur);
    return (ex_we && ex_waddr_i == a) ? ex_nv : (cl_we && clint_waddr_i == a) ? cl_nv : cur;
  endfunction
  assign ex_rd  = csr_read(ex_raddr_i);
  assign cl_rd  = csr_read(clint_raddr_i);
  assign ex_old = csr_read(ex_waddr_i);
  assign cl_old = csr_read(clint_waddr_i);
  assign ex_we  = ex_op_i != CSR_OP_NONE;
  assign cl_we  = clint_op_i != CSR_OP_NONE && !(ex_we && ex_waddr_i == clint_waddr_i);
  assign ex_nv  = XLEN'(csr_apply(csr_op_e'(ex_op_i), 64'(ex_old), 64'(ex_wdata_i)));
  assign cl_nv  = XLEN'(csr_apply(csr_op_e'(clint_op_i), 64'(cl_old), 64'(clint_wdata_i)));
  always_comb begin
    mstatus_d  = wr_val(CSR_MSTATUS, mstatus_q) & MST_M;
    mie_d      = wr_val(CSR_MIE, mie_q) & MIE_M;
    mtvec_d    = wr_val(CSR_MTVEC, mtvec_q) & ALN_M;
    mscratch_d = wr_val(CSR_MSCRATCH, mscratch_q);
    mepc_d     = wr_val(CSR_MEPC, mepc_q) & ALN_M;
    mcause_d   = wr_val(CSR_MCAUSE, mcause_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_q  <= '0;
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RST;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else begin
      mstatus_q  <= mstatus_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
    end
  end
  csr_counter #(.CNT_W(CNT_W), .XLEN(XLEN)) u_mcycle (
    .clk        (clk),
    .rst        (rst),
    .inc_i      (1'b1),
    .wr_lo_i    (wr_hit(CSR_MCYCLE)),
    .wr_hi_i    (wr_hit(CSR_MCYCLEH)),
    .wdata_lo_i (wr_val(CSR_MCYCLE, '0)),
    .wdata_hi_i (HW'(wr_val(CSR_MCYCLEH, '0))),
    .q_o        (mcycle_q)
  );
  if (HAS_INSTRET) begin : g_instret
    csr_counter #(.CNT_W(CNT_W), .XLEN(XLEN)) u_minstret (
      .clk        (clk),
      .rst        (rst),
      .inc_i      (instret_i),
      .wr_lo_i    (wr_hit(CSR_MINSTRET)),
      .wr_hi_i    (wr_hit(CSR_MINSTRETH)),
      .wdata_lo_i (wr_val(CSR_MINSTRET, '0)),
      .wdata_hi_i (HW'(wr_val(CSR_MINSTRETH, '0))),
      .q_o        (minstret_q)
    );
  end else begin : g_no_instret
    assign minstret_q = '0;
  end
  assign ex_rdata_o      = (rst || ex_rd[XLEN]) ? '0 : ex_rd[XLEN-1:0];
  assign ex_illegal_o    = !rst && ex_rd[XLEN];
  assign clint_rdata_o   = (rst || cl_rd[XLEN]) ? '0 : cl_rd[XLEN-1:0];
  assign global_int_en_o = !rst && mstatus_q[3];
  assign mie_o           = rst ? '0 : mie_q;
endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: randomized and directed checks of csr_file against a behavioural register model
module tb_csr_file;
  logic        clk = 1'b0, rst = 1'b1, instret_i = 1'b0;
  logic [1:0]  ex_op_i = '0, clint_op_i = '0;
  logic [11:0] ex_waddr_i = '0, ex_raddr_i = '0, clint_waddr_i = '0, clint_raddr_i = '0;
  logic [31:0] ex_wdata_i = '0, clint_wdata_i = '0;
  logic [31:0] ex_rdata_o, clint_rdata_o, mie_o;
  logic        ex_illegal_o, global_int_en_o;
  int tests = 0, fails = 0;
  csr_file dut (
    .clk(clk), .rst(rst), .instret_i(instret_i),
    .ex_op_i(ex_op_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
    .ex_raddr_i(ex_raddr_i), .ex_rdata_o(ex_rdata_o), .ex_illegal_o(ex_illegal_o),
    .clint_op_i(clint_op_i), .clint_waddr_i(clint_waddr_i), .clint_wdata_i(clint_wdata_i),
    .clint_raddr_i(clint_raddr_i), .clint_rdata_o(clint_rdata_o),
    .global_int_en_o(global_int_en_o), .mie_o(mie_o)
  );
  always #5 clk = ~clk;
  bit [31:0] m_mst, m_mie, m_mtv, m_msc, m_mep, m_mca;
  bit [63:0] m_cyc, m_ins;
  bit cw, iw;
  function automatic bit [32:0] m_rd(input bit [11:0] a);
    case (a)
      12'h300: return {1'b0, m_mst};
      12'h304: return {1'b0, m_mie};
      12'h305: return {1'b0, m_mtv};
      12'h340: return {1'b0, m_msc};
      12'h341: return {1'b0, m_mep};
      12'h342: return {1'b0, m_mca};
      12'hB00, 12'hC00: return {1'b0, m_cyc[31:0]};
      12'hB80, 12'hC80: return {1'b0, m_cyc[63:32]};
      12'hB02, 12'hC02: return {1'b0, m_ins[31:0]};
      12'hB82, 12'hC82: return {1'b0, m_ins[63:32]};
      default: return {1'b1, 32'h0};
    endcase
  endfunction
  function automatic bit [31:0] m_apply(input bit [1:0] op, input bit [32:0] old, input bit [31:0] d);
    case (op)
      2'b01: return d;
      2'b10: return old[31:0] | d;
      2'b11: return old[31:0] & ~d;
      default: return old[31:0];
    endcase
  endfunction
  task automatic m_put(input bit [11:0] a, input bit [31:0] v);
    case (a)
      12'h300: m_mst = v & 32'h88;
      12'h304: m_mie = v & 32'h888;
      12'h305: m_mtv = v & ~32'h3;
      12'h340: m_msc = v;
      12'h341: m_mep = v & ~32'h3;
      12'h342: m_mca = v;
      12'hB00: begin m_cyc[31:0] = v; cw = 1'b1; end
      12'hB80: begin m_cyc[63:32] = v; cw = 1'b1; end
      12'hB02: begin m_ins[31:0] = v; iw = 1'b1; end
      12'hB82: begin m_ins[63:32] = v; iw = 1'b1; end
      default: ;
    endcase
  endtask
  always @(posedge clk) begin : model
    bit [31:0] en, cn;
    if (rst) begin
      m_mst = 0; m_mie = 0; m_mtv = 0; m_msc = 0; m_mep = 0; m_mca = 0; m_cyc = 0; m_ins = 0;
    end else begin
      en = m_apply(ex_op_i, m_rd(ex_waddr_i), ex_wdata_i);
      cn = m_apply(clint_op_i, m_rd(clint_waddr_i), clint_wdata_i);
      cw = 1'b0;
      iw = 1'b0;
      if (clint_op_i != 2'b00) m_put(clint_waddr_i, cn);
      if (ex_op_i != 2'b00) m_put(ex_waddr_i, en);
      if (!cw) m_cyc = m_cyc + 1;
      if (!iw && instret_i) m_ins = m_ins + 1;
    end
  end
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin : compare
    bit [32:0] e, c;
    e = m_rd(ex_raddr_i);
    c = m_rd(clint_raddr_i);
    chk("ex_rdata", ex_rdata_o, rst ? 32'h0 : e[31:0]);
    chk("ex_illegal", {31'h0, ex_illegal_o}, rst ? 32'h0 : {31'h0, e[32]});
    chk("clint_rdata", clint_rdata_o, rst ? 32'h0 : c[31:0]);
    chk("global_int_en", {31'h0, global_int_en_o}, rst ? 32'h0 : {31'h0, m_mst[3]});
    chk("mie_o", mie_o, rst ? 32'h0 : m_mie);
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic look(input logic [11:0] ea, input logic [11:0] ca);
    ex_raddr_i = ea;
    clint_raddr_i = ca;
    #1;
  endtask
  task automatic wr(input logic [1:0] eo, input logic [11:0] ea, input logic [31:0] ed,
                    input logic [1:0] co, input logic [11:0] ca, input logic [31:0] cd);
    ex_op_i = eo; ex_waddr_i = ea; ex_wdata_i = ed;
    clint_op_i = co; clint_waddr_i = ca; clint_wdata_i = cd;
    cyc();
    ex_op_i = 2'b00;
    clint_op_i = 2'b00;
  endtask
  function automatic logic [11:0] pick();
    logic [11:0] pool [15] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00,
                               12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'h7C0};
    int i = $urandom_range(0, 15);
    return i == 15 ? 12'($urandom) : pool[i];
  endfunction
  initial begin
    repeat (3) cyc();
    rst = 1'b0;
    repeat (10) cyc();
    look(12'hC00, 12'hC80);
    chk("cycle after 10 idle", ex_rdata_o, 32'd10);
    chk("cycleh after 10 idle", clint_rdata_o, 32'd0);
    chk("illegal on cycle", {31'h0, ex_illegal_o}, 32'h0);
    look(12'h305, 12'h7C0);
    chk("mtvec reset", ex_rdata_o, 32'h0);
    chk("illegal on mtvec", {31'h0, ex_illegal_o}, 32'h0);
    wr(2'b01, 12'h300, 32'hFFFF_FFFF, 2'b00, 12'h0, 32'h0);
    look(12'h300, 12'h300);
    chk("mstatus write mask", ex_rdata_o, 32'h88);
    chk("gie set", {31'h0, global_int_en_o}, 32'h1);
    wr(2'b11, 12'h300, 32'h8, 2'b00, 12'h0, 32'h0);
    look(12'h300, 12'h300);
    chk("mstatus clear", ex_rdata_o, 32'h80);
    chk("gie clear", {31'h0, global_int_en_o}, 32'h0);
    wr(2'b01, 12'h304, 32'hFFFF_FFFF, 2'b00, 12'h0, 32'h0);
    chk("mie mask", mie_o, 32'h888);
    wr(2'b01, 12'h341, 32'h1237, 2'b01, 12'h342, 32'h8000_0007);
    look(12'h341, 12'h342);
    chk("mepc align", ex_rdata_o, 32'h1234);
    chk("mcause dual", clint_rdata_o, 32'h8000_0007);
    wr(2'b01, 12'h340, 32'hA, 2'b01, 12'h340, 32'hB);
    look(12'h340, 12'h340);
    chk("mscratch ex wins", ex_rdata_o, 32'hA);
    wr(2'b01, 12'hB00, 32'hFFFF_FFFF, 2'b01, 12'hB80, 32'h0);
    look(12'hB00, 12'hB80);
    chk("mcycle lo write", ex_rdata_o, 32'hFFFF_FFFF);
    chk("mcycle hi write", clint_rdata_o, 32'h0);
    cyc();
    look(12'hB00, 12'hB80);
    chk("mcycle lo wrap", ex_rdata_o, 32'h0);
    chk("mcycle hi carry", clint_rdata_o, 32'h1);
    wr(2'b01, 12'hC00, 32'h5, 2'b00, 12'h0, 32'h0);
    look(12'hC00, 12'hC80);
    chk("cycle alias ro", ex_rdata_o, 32'h1);
    chk("cycleh alias ro", clint_rdata_o, 32'h1);
    for (int i = 0; i < 5; i++) begin
      instret_i = 1'b1;
      if (i == 2) begin ex_op_i = 2'b01; ex_waddr_i = 12'hB02; ex_wdata_i = 32'd100; end
      cyc();
      ex_op_i = 2'b00;
    end
    instret_i = 1'b0;
    look(12'hB02, 12'hC82);
    chk("minstret after write", ex_rdata_o, 32'd102);
    chk("instreth", clint_rdata_o, 32'd0);
    look(12'h7C0, 12'h7C0);
    chk("unimpl rdata", ex_rdata_o, 32'h0);
    chk("unimpl illegal", {31'h0, ex_illegal_o}, 32'h1);
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      instret_i = 1'($urandom);
      ex_op_i = 2'($urandom);
      clint_op_i = 2'($urandom);
      ex_waddr_i = pick();
      clint_waddr_i = ($urandom_range(0, 3) == 0) ? ex_waddr_i : pick();
      ex_wdata_i = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      clint_wdata_i = $urandom;
      ex_raddr_i = pick();
      clint_raddr_i = pick();
      cyc();
    end
    rst = 1'b0;
    instret_i = 1'b0;
    wr(2'b01, 12'h300, 32'hFFFF_FFFF, 2'b01, 12'h304, 32'hFFFF_FFFF);
    rst = 1'b1;
    wr(2'b01, 12'h300, 32'hFFFF_FFFF, 2'b01, 12'h340, 32'h1234_5678);
    rst = 1'b0;
    look(12'h300, 12'h340);
    chk("mstatus after rst", ex_rdata_o, 32'h0);
    chk("mscratch after rst", clint_rdata_o, 32'h0);
    chk("gie after rst", {31'h0, global_int_en_o}, 32'h0);
    look(12'hC00, 12'h305);
    chk("cycle after rst", ex_rdata_o, 32'h0);
    chk("mtvec after rst", clint_rdata_o, 32'h0);
    cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
